// File: rtl/hamming_encode_if.sv
// Handshake bundle for the SECDED encoder: payload in, codeword out, transfer count.
// Adds the inject_mode_i/inject_pos_i controls when HAMMING_ERR_INJECT_EN is defined.
interface hamming_encode_if #(
    parameter int DATA_WIDTH  = 25,
    parameter int ADDR_WIDTH  = 5,
    parameter int CODED_WIDTH = 31
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [DATA_WIDTH-1:0]  data_in_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [CODED_WIDTH-1:0] coded_out_o;
    logic [31:0]            words_encoded_o;
`ifdef HAMMING_ERR_INJECT_EN
    logic [1:0]             inject_mode_i;
    logic [ADDR_WIDTH-1:0]  inject_pos_i;

    modport slave (
        input  in_valid_i, data_in_i, out_ready_i, inject_mode_i, inject_pos_i,
        output in_ready_o, out_valid_o, coded_out_o, words_encoded_o
    );
    modport master (
        output in_valid_i, data_in_i, out_ready_i, inject_mode_i, inject_pos_i,
        input  in_ready_o, out_valid_o, coded_out_o, words_encoded_o
    );
`else
    modport slave (
        input  in_valid_i, data_in_i, out_ready_i,
        output in_ready_o, out_valid_o, coded_out_o, words_encoded_o
    );
    modport master (
        output in_valid_i, data_in_i, out_ready_i,
        input  in_ready_o, out_valid_o, coded_out_o, words_encoded_o
    );
`endif
endinterface

// File: rtl/hamming_encode.sv
// Two-stage pipelined SECDED Hamming encoder, codeword layout bit-exact with the team decoder.
// Optional error injection at stage 2 is enabled by defining HAMMING_ERR_INJECT_EN.
module hamming_encode #(
    parameter int DATA_WIDTH = 25
) (
    input logic             clk,
    input logic             rst,
    hamming_encode_if.slave bus
);
    // Closed form of hamming_address_width: smallest r with 2^r >= DATA_WIDTH + r + 1.
    localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1);
    localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;

    // Codeword position of data bit idx: the idx-th non-power-of-two position from 1 upward.
    function automatic int data_pos(input int idx);
        int seen;
        seen     = 0;
        data_pos = 0;
        for (int p = 1; p < CODED_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (seen == idx) data_pos = p;
                seen++;
            end
        end
    endfunction

    logic                   s1_valid, s2_valid;
    logic                   s1_load, s2_load;
    logic [DATA_WIDTH-1:0]  s1_data;
    logic [CODED_WIDTH-1:0] s1_placed, placed, codeword, coded;
    logic [31:0]            count;
    logic                   parity;

    assign s2_load = !s2_valid || bus.out_ready_i;
    assign s1_load = !s1_valid || s2_load;

    always_comb begin
        placed = '0;
        for (int j = 0; j < DATA_WIDTH; j++) placed[data_pos(j)] = bus.data_in_i[j];
    end

`ifdef HAMMING_ERR_INJECT_EN
    logic [1:0]             s1_mode;
    logic [ADDR_WIDTH-1:0]  s1_pos, s1_pos_pair;
    logic [CODED_WIDTH-1:0] flip;

    assign s1_pos_pair = s1_pos ^ {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Flips that would land beyond the codeword are dropped rather than wrapped.
    always_comb begin
        flip = '0;
        if (s1_mode == 2'd1 || s1_mode == 2'd2) begin
            if (int'(s1_pos) < CODED_WIDTH) flip[s1_pos] = 1'b1;
        end
        if (s1_mode == 2'd2) begin
            if (int'(s1_pos_pair) < CODED_WIDTH) flip[s1_pos_pair] = 1'b1;
        end
    end
`endif

    always_comb begin
        codeword = s1_placed;
        parity   = 1'b0;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            parity = 1'b0;
            for (int j = 0; j < DATA_WIDTH; j++) begin
                if (((data_pos(j) >> k) & 1) != 0) parity = parity ^ s1_data[j];
            end
            codeword[1 << k] = parity;
        end
        codeword[0] = ^codeword[CODED_WIDTH-1:1];
`ifdef HAMMING_ERR_INJECT_EN
        codeword = codeword ^ flip;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            coded    <= '0;
            count    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    s1_data   <= bus.data_in_i;
                    s1_placed <= placed;
`ifdef HAMMING_ERR_INJECT_EN
                    s1_mode   <= bus.inject_mode_i;
                    s1_pos    <= bus.inject_pos_i;
`endif
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) coded <= codeword;
            end
            if (s2_valid && bus.out_ready_i) count <= count + 32'd1;
        end
    end

    assign bus.in_ready_o      = s1_load;
    assign bus.out_valid_o     = s2_valid;
    assign bus.coded_out_o     = coded;
    assign bus.words_encoded_o = count;
endmodule

// File: tb/tb_hamming_encode.sv
// Self-checking bench for hamming_encode: fixed vectors, stall/reset sequences, random stream.
module tb_hamming_encode;
    localparam int DW = 25;
    localparam int AW = 5;
    localparam int CW = 31;

    typedef struct {
        string           name;
        logic [DW-1:0]   data;
        logic [CW-1:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_encode_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CODED_WIDTH(CW)) bus ();
    hamming_encode #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    // Reference: place data in non-power-of-two slots, then choose parity bits so that
    // the XOR of all set-bit indices is zero, then add overall even parity in bit 0.
    function automatic logic [CW-1:0] ref_encode(input logic [DW-1:0] d);
        logic [CW-1:0] w;
        int j, syn;
        w = '0; j = 0; syn = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p] = d[j];
                j++;
            end
        end
        for (int p = 1; p < CW; p++) if (w[p]) syn = syn ^ p;
        for (int k = 0; k < AW; k++) w[1 << k] = ((syn >> k) & 1) != 0;
        w[0] = ^w;
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_get(input logic [DW-1:0] d, output logic [CW-1:0] got);
        bus.in_valid_i  = 1'b1;
        bus.data_in_i   = d;
        bus.out_ready_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        bus.inject_mode_i = 2'd0;
        bus.inject_pos_i  = '0;
`endif
        for (int i = 0; i < 10 && !bus.out_valid_o; i++) tick();
        if (!bus.out_valid_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: out_valid never rose for data %h", d);
        end
        got = bus.coded_out_o;
        tick();
        exp_cnt++;
    endtask

    initial begin
        vec_t          vecs[5];
        logic [CW-1:0] got, ca, cb, prev_coded;
        logic [CW-1:0] q[$];
        int            sent, rcvd, cycles;
        logic          prev_stall;

        vecs[0] = '{"zero",     25'h0000000, 31'h00000000};
        vecs[1] = '{"bit0",     25'h0000001, 31'h0000000F};
        vecs[2] = '{"bit1",     25'h0000002, 31'h00000033};
        vecs[3] = '{"bit2",     25'h0000004, 31'h00000055};
        vecs[4] = '{"all_ones", 25'h1FFFFFF, 31'h7FFEFEE9};

        bus.in_valid_i  = 1'b0;
        bus.data_in_i   = '0;
        bus.out_ready_i = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        bus.inject_mode_i = 2'd0;
        bus.inject_pos_i  = '0;
`endif

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_coded", 64'(bus.coded_out_o), 64'd0);
        check("rst_count", 64'(bus.words_encoded_o), 64'd0);
        rst = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Latency: accepted at edge A, visible after edge A+1
        bus.in_valid_i  = 1'b1;
        bus.data_in_i   = '0;
        bus.out_ready_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        check("lat_cycle1_valid", 64'(bus.out_valid_o), 64'd0);
        tick();
        check("lat_cycle2_valid", 64'(bus.out_valid_o), 64'd1);
        check("lat_coded", 64'(bus.coded_out_o), 64'd0);
        tick();
        exp_cnt = 1;
        check("lat_count", 64'(bus.words_encoded_o), 64'd1);

        foreach (vecs[i]) begin
            send_and_get(vecs[i].data, got);
            check(vecs[i].name, 64'(got), 64'(vecs[i].exp));
        end
        check("table_count", 64'(bus.words_encoded_o), 64'(exp_cnt));

        // Fill both stages under backpressure; a third word must be refused
        ca = ref_encode(25'h0ABCDEF);
        cb = ref_encode(25'h1234567);
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.data_in_i   = 25'h0ABCDEF;
        tick();
        bus.data_in_i = 25'h1234567;
        tick();
        bus.data_in_i = 25'h1555555;
        check("full_out_valid", 64'(bus.out_valid_o), 64'd1);
        check("full_coded_a", 64'(bus.coded_out_o), 64'(ca));
        check("full_in_ready", 64'(bus.in_ready_o), 64'd0);
        tick();
        check("full_hold_coded", 64'(bus.coded_out_o), 64'(ca));
        check("full_hold_ready", 64'(bus.in_ready_o), 64'd0);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        check("drain_coded_b", 64'(bus.coded_out_o), 64'(cb));
        check("drain_valid_b", 64'(bus.out_valid_o), 64'd1);
        tick();
        check("drain_empty", 64'(bus.out_valid_o), 64'd0);
        exp_cnt += 2;
        check("drain_count", 64'(bus.words_encoded_o), 64'(exp_cnt));

        // Reset with both stages full
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.data_in_i   = 25'h0000F0F;
        tick();
        bus.data_in_i = 25'h00F0F00;
        tick();
        bus.in_valid_i = 1'b0;
        check("prerst_full", 64'(bus.out_valid_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_count", 64'(bus.words_encoded_o), 64'd0);
        check("midrst_coded", 64'(bus.coded_out_o), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready_o), 64'd1);
        tick();
        check("midrst_discarded", 64'(bus.out_valid_o), 64'd0);
        exp_cnt = 0;

        // Random stream of 100 words with random backpressure
        sent = 0; rcvd = 0; cycles = 0; prev_stall = 1'b0; prev_coded = '0;
        while (rcvd < 100 && cycles < 3000) begin
            bus.in_valid_i  = (sent < 100) && ($urandom_range(0, 3) != 0);
            bus.data_in_i   = DW'($urandom);
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            #1;
            check("rand_in_ready", 64'(bus.in_ready_o),
                  64'(!(q.size() == 2 && !bus.out_ready_i)));
            if (prev_stall) check("rand_stable", 64'(bus.coded_out_o), 64'(prev_coded));
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rand_extra: unexpected codeword %h", bus.coded_out_o);
                end else begin
                    check("rand_coded", 64'(bus.coded_out_o), 64'(q.pop_front()));
                end
                rcvd++;
                exp_cnt++;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                q.push_back(ref_encode(bus.data_in_i));
                sent++;
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_coded = bus.coded_out_o;
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        check("rand_received", 64'(rcvd), 64'd100);
        check("rand_count", 64'(bus.words_encoded_o), 64'd100);

`ifdef HAMMING_ERR_INJECT_EN
        bus.inject_mode_i = 2'd1; bus.inject_pos_i = 5'd7;
        send_and_get(25'h0, got);
        check("inj_single_7", 64'(got), 64'h80);
        bus.inject_mode_i = 2'd2; bus.inject_pos_i = 5'd6;
        send_and_get(25'h0, got);
        check("inj_double_6", 64'(got), 64'hC0);
        bus.inject_mode_i = 2'd2; bus.inject_pos_i = 5'd0;
        send_and_get(25'h1, got);
        check("inj_double_0", 64'(got), 64'h0C);
        bus.inject_mode_i = 2'd1; bus.inject_pos_i = 5'd31;
        send_and_get(25'h0, got);
        check("inj_suppress", 64'(got), 64'h0);
        bus.inject_mode_i = 2'd3; bus.inject_pos_i = 5'd7;
        send_and_get(25'h1, got);
        check("inj_mode3", 64'(got), 64'h0F);
        check("inj_count", 64'(bus.words_encoded_o), 64'(exp_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
